spi_frame_scheduler: RTL

- Sits in the system `clk` domain beside the SPI slave shifter, which runs on the external DClk.
- Services the shifter's TxGetNext toggle by arbitrating round-robin between two 128-bit packet sources, with an idle-packet fallback, and holds the result stable on tx_packet.
- Decodes 32-bit command frames flagged by the shifter's PktComplete toggle into a small config register set: source enables and the idle pattern.
- Keeps underrun and command statistics for host readback.

---
 rtl/spi_frame_scheduler.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_scheduler.sv
// Packet scheduler for the SPI slave shifter: round-robin arbitration over two packet
// sources with idle fill, plus a small command-frame config register set and statistics.

module spi_toggle_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic ev
);
   logic [2:0] sr;

   // Preloading every stage with the live input keeps reset from producing a false edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= {3{din}};
      end else begin
         sr <= {sr[1:0], din};
      end
   end

   assign ev = sr[2] ^ sr[1];
endmodule

// state  | meaning
// IDLE   | waiting for a TxGetNext event or a pending request
// SELECT | arbitrate, load tx_packet, pulse the granted source's ready
// HOLD   | one settling cycle before the next request is serviced
module spi_frame_scheduler #(
   parameter logic [15:0] IDLE_DEFAULT = 16'hA5A5,
   parameter logic [3:0]  CMD_KEY      = 4'hC
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tx_get_next_tgl,
   input  logic         pkt_complete_tgl,
   input  logic [31:0]  rxed_frame,
   output logic [127:0] tx_packet,
   input  logic [127:0] src0_data,
   input  logic         src0_valid,
   output logic         src0_ready,
   input  logic [127:0] src1_data,
   input  logic         src1_valid,
   output logic         src1_ready,
   output logic [1:0]   src_enable,
   output logic [15:0]  underrun_cnt,
   output logic [7:0]   cmd_cnt,
   output logic [7:0]   bad_cmd_cnt
);
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic        req_ev;
   logic        cmd_ev;
   logic        pending, pending_nxt;
   logic        rr_ptr, rr_ptr_nxt;
   logic        grant0, grant1, idle_issue;
   logic        elig0, elig1;
   logic [15:0] idle_word;

   logic [3:0]  cmd_key;
   logic [3:0]  cmd_addr;
   logic        cmd_ok, cmd_bad, cmd_clr;

   spi_toggle_sync u_req_sync (
      .clk (clk),
      .rst (rst),
      .din (tx_get_next_tgl),
      .ev  (req_ev)
   );

   spi_toggle_sync u_cmd_sync (
      .clk (clk),
      .rst (rst),
      .din (pkt_complete_tgl),
      .ev  (cmd_ev)
   );

   assign elig0 = src0_valid & src_enable[0];
   assign elig1 = src1_valid & src_enable[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         pending <= 1'b0;
         rr_ptr  <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         rr_ptr  <= rr_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      rr_ptr_nxt  = rr_ptr;
      grant0      = 1'b0;
      grant1      = 1'b0;
      idle_issue  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_ev || pending) begin
               state_nxt   = ST_SELECT;
               pending_nxt = 1'b0;
            end
         end
         ST_SELECT: begin
            if (req_ev) begin
               pending_nxt = 1'b1;
            end
            if (elig0 && elig1) begin
               grant0     = ~rr_ptr;
               grant1     = rr_ptr;
               rr_ptr_nxt = ~rr_ptr;
            end else if (elig0) begin
               grant0     = 1'b1;
               rr_ptr_nxt = 1'b1;
            end else if (elig1) begin
               grant1     = 1'b1;
               rr_ptr_nxt = 1'b0;
            end else begin
               idle_issue = 1'b1;
            end
            state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (req_ev) begin
               pending_nxt = 1'b1;
            end
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt   = ST_IDLE;
            pending_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_packet  <= {8{IDLE_DEFAULT}};
         src0_ready <= 1'b0;
         src1_ready <= 1'b0;
      end else begin
         src0_ready <= grant0;
         src1_ready <= grant1;
         if (grant0) begin
            tx_packet <= src0_data;
         end else if (grant1) begin
            tx_packet <= src1_data;
         end else if (idle_issue) begin
            tx_packet <= {8{idle_word}};
         end
      end
   end

   assign cmd_key  = rxed_frame[31:28];
   assign cmd_addr = rxed_frame[27:24];
   assign cmd_ok   = cmd_ev && (cmd_key == CMD_KEY) && (cmd_addr <= 4'd2);
   assign cmd_bad  = cmd_ev && !cmd_ok;
   assign cmd_clr  = cmd_ok && (cmd_addr == 4'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         src_enable <= 2'b11;
         idle_word  <= IDLE_DEFAULT;
      end else begin
         if (cmd_ok && (cmd_addr == 4'd0)) begin
            src_enable <= rxed_frame[1:0];
         end
         if (cmd_ok && (cmd_addr == 4'd1)) begin
            idle_word <= rxed_frame[15:0];
         end
      end
   end

   // A clear command overrides any same-cycle underrun, then counts itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         underrun_cnt <= 16'd0;
         cmd_cnt      <= 8'd0;
         bad_cmd_cnt  <= 8'd0;
      end else begin
         if (cmd_clr) begin
            underrun_cnt <= 16'd0;
         end else if (idle_issue && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
         end

         if (cmd_clr) begin
            cmd_cnt <= 8'd1;
         end else if (cmd_ok) begin
            cmd_cnt <= cmd_cnt + 8'd1;
         end

         if (cmd_clr) begin
            bad_cmd_cnt <= 8'd0;
         end else if (cmd_bad) begin
            bad_cmd_cnt <= bad_cmd_cnt + 8'd1;
         end
      end
   end
endmodule
